gpio_pio_arbiter: RTL
=====================

Name: gpio_pio_arbiter

Overview:
- Round-robin arbiter that shares one 32-bit PIO Avalon-MM slave between NUM_REQ independent requesters, e.g. CPU bridge, test sequencer and LED/status engine.
- Serialises accesses onto the PIO slave port: 2-bit address, chipselect, write_n, writedata, and readdata registered with 1-cycle latency.
- Returns read data or a write acknowledge to the originating requester.
- Sits between the requesters and the PIO slave in the board-level system.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 32, PIO data width.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous reset, active-high.
- req_valid  input  NUM_REQ  per-requester request pending.
- req_write  input  NUM_REQ  1 = write, 0 = read, per requester.
- req_addr  input  2*NUM_REQ  PIO register address, requester i at bits [2i+1:2i].
- req_wdata  input  DATA_W*NUM_REQ  write data, requester i at bits [DATA_W*i +: DATA_W].
- req_ready  output  NUM_REQ  one-hot, 1-cycle pulse: request accepted.
- rsp_valid  output  NUM_REQ  one-hot, 1-cycle pulse: transaction complete.
- rsp_rdata  output  DATA_W  read data, qualified by rsp_valid; 0 for writes.
- busy  output  1  high while a transaction is in ISSUE or RESP.
- pio_address  output  2  to PIO slave.
- pio_chipselect  output  1  to PIO slave.
- pio_write_n  output  1  to PIO slave, active-low write strobe.
- pio_writedata  output  DATA_W  to PIO slave.
- pio_readdata  input  DATA_W  from PIO slave; registered, valid the cycle after the address is presented.

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, busy=0, pio_chipselect=0, pio_write_n=1, pio_address=0, pio_writedata=0. FSM=IDLE, round-robin pointer=0, so requester 0 has highest priority first.
- Requester protocol:
  - Assert req_valid with req_write, req_addr and req_wdata stable, and hold until req_ready.
  - Dropping req_valid before req_ready is a protocol violation; behaviour is unspecified.
  - A requester may re-request the cycle after its rsp_valid.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If any req_valid, select winner w = first asserted index searching ptr, ptr+1, ... modulo NUM_REQ.
  - Register w's command into internal cmd registers.
  - Pulse req_ready[w] this cycle, combinationally from the IDLE decode.
  - Set ptr <= (w+1) mod NUM_REQ.
  - Next state ISSUE.
  - If no req_valid, stay in IDLE and hold ptr.
- ISSUE, exactly 1 cycle:
  - pio_chipselect=1, pio_address=cmd_addr, pio_writedata=cmd_wdata, pio_write_n=~cmd_write.
  - Next state RESP.
- RESP, exactly 1 cycle:
  - pio_chipselect=0, pio_write_n=1.
  - rsp_valid[w]=1.
  - rsp_rdata = pio_readdata for reads, 0 for writes.
  - Next state IDLE.
- Fixed cost: 3 cycles per transaction. Sustained throughput is 1 transaction per 3 cycles under continuous demand.
- busy=1 in ISSUE and RESP.
- pio_address and pio_writedata hold their last value outside ISSUE. The PIO ignores them without chipselect, except that readdata tracks address; that is harmless.
- Fairness: under continuous requests from all requesters, grants rotate 0,1,..,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 other transactions.
- Simultaneous events:
  - A new req_valid arriving during ISSUE/RESP waits for IDLE.
  - The winner's own req_valid, still high in the cycle after req_ready, is not a new request. The requester must deassert after req_ready; the arbiter samples again only in IDLE.
- Read/write addresses: any of the 4 values are passed through. Reads of addresses other than 0 return whatever the PIO returns (0).
- Reset mid-transaction: FSM goes to IDLE and all outputs take reset values next cycle. No rsp_valid is issued for the aborted transaction; requesters must reissue.
- Width rule: rsp_rdata is exactly DATA_W bits and is not extended.

Test Plan:
- Single read: req0 read addr 0, PIO in_port=0xA5A5_1234 → req_ready[0] at T, pio_chipselect=1 & write_n=1 at T+1, rsp_valid[0]=1 & rsp_rdata=0xA5A5_1234 at T+2.
- Single write: req2 write addr 0 data 0xDEAD_BEEF → pio_write_n=0 for exactly 1 cycle, PIO out_port=0xDEAD_BEEF afterwards, rsp_valid[2] with rsp_rdata=0.
- Contention: all 4 requesters hold req_valid from reset → grant order 0,1,2,3,0, each grant 3 cycles apart, exactly one rsp_valid per grant to the correct index.
- Pointer fairness: req1 and req3 continuously, after one grant to req1 → next grant req3, then req1, alternating; no starvation over 100 transactions.
- Reset mid-op: assert reset during ISSUE of a write → pio_chipselect=0 next cycle, no rsp_valid, ptr=0; req0 and req1 pending after reset → req0 granted first.
- Idle hold: no req_valid for 50 cycles → pio_chipselect=0, busy=0, ptr unchanged.

Source files
------------

// File: rtl/gpio_pio_arbiter.sv
// gpio_pio_arbiter
// Round-robin arbiter that shares one PIO Avalon-MM slave between several
// requesters. Each transaction costs three cycles:
//   IDLE  : pick a winner, pulse its req_ready and capture its command.
//   ISSUE : present the command to the PIO with chipselect raised.
//   RESP  : return the PIO's registered readdata to the winner with rsp_valid.
// The PIO address and write data come straight from the command registers.
// They therefore hold the last command's value while no access is running.
module gpio_pio_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [2*NUM_REQ-1:0]      req_addr,
  input  logic [DATA_W*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      busy,
  output logic [1:0]                pio_address,
  output logic                      pio_chipselect,
  output logic                      pio_write_n,
  output logic [DATA_W-1:0]         pio_writedata,
  input  logic [DATA_W-1:0]         pio_readdata
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  logic [1:0]        state;
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  win;
  logic [PTR_W-1:0]  cand;
  logic [PTR_W-1:0]  ptr_next;
  logic              found;
  logic              grant;

  logic              cmd_write;
  logic [1:0]        cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [PTR_W-1:0]  cmd_idx;

  // Search the requests from ptr upwards and wrap around; the first pending requester wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = PTR_W'((int'(ptr) + i) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // A grant happens only in IDLE. It is held off during reset so that no acceptance pulse gets lost.
  assign grant     = found && (state == S_IDLE) && !reset;
  assign req_ready = grant ? (NUM_REQ'(1) << win) : '0;
  assign ptr_next  = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;

  // State, pointer and command capture. Reset abandons any in-flight access without a response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      ptr       <= '0;
      cmd_write <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      cmd_idx   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant) begin
            cmd_write <= req_write[win];
            cmd_addr  <= req_addr[2*int'(win) +: 2];
            cmd_wdata <= req_wdata[DATA_W*int'(win) +: DATA_W];
            cmd_idx   <= win;
            ptr       <= ptr_next;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: state <= S_RESP;
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy           = (state == S_ISSUE) || (state == S_RESP);
  assign pio_chipselect = (state == S_ISSUE);
  assign pio_write_n    = !((state == S_ISSUE) && cmd_write);
  assign pio_address    = cmd_addr;
  assign pio_writedata  = cmd_wdata;

  // The PIO returns readdata one cycle after the address, so it is valid in RESP.
  assign rsp_valid = (state == S_RESP) ? (NUM_REQ'(1) << cmd_idx) : '0;
  assign rsp_rdata = ((state == S_RESP) && !cmd_write) ? pio_readdata : '0;

endmodule
